// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes little-endian into instruction words and writes them to instruction memory.
// Optional checksum byte after HALT is enabled by defining LOADER_CHECKSUM_EN.
module uart_prog_loader #(
    parameter int                 NB_DATA     = 8,
    parameter int                 NB_WORD     = 32,
    parameter int                 NB_ADDR     = 8,
    parameter logic [NB_WORD-1:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int                 TIMEOUT_CYC = 1000000,
    parameter int                 NB_TIMEOUT  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_start,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_WORD-1:0] o_mem_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR:0]   o_word_count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;
`endif

    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYC - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic [1:0]            idx_r;
    logic [NB_TIMEOUT-1:0] tmo_r;
    logic [NB_WORD-1:0]    word_r;
    logic [NB_WORD-1:0]    assembled_s;
    logic                  accept_s;
    logic                  start_s;
    logic                  tmo_hit_s;
    logic                  we_r;
    logic [NB_ADDR-1:0]    addr_r;
    logic [NB_WORD-1:0]    data_r;
    logic [NB_ADDR:0]      count_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
`ifdef LOADER_CHECKSUM_EN
    logic [NB_DATA-1:0]    xor_r;
`endif

    // busy covers every state in which a load is still in flight
    function automatic logic is_busy(input state_t st);
`ifdef LOADER_CHECKSUM_EN
        return (st == RECV) || (st == WRITE) || (st == CHECK);
`else
        return (st == RECV) || (st == WRITE);
`endif
    endfunction

    // Current word with the incoming byte dropped into its little-endian slot
    always_comb begin
        assembled_s = word_r;
        assembled_s[idx_r*NB_DATA +: NB_DATA] = i_rx_data;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and byte acceptance
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        start_s      = 1'b0;
        tmo_hit_s    = (tmo_r == TMO_LAST);
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    start_s      = 1'b1;
                    next_state_s = RECV;
                end else begin
                    next_state_s = state_r;
                end
            end
            RECV: begin
                if (i_rx_done) begin
                    accept_s     = 1'b1;
                    next_state_s = (idx_r == 2'd3) ? WRITE : RECV;
                end else if ((idx_r != 2'd0) && tmo_hit_s) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = RECV;
                end
            end
            WRITE: begin
                if (data_r == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state_s = CHECK;
`else
                    next_state_s = DONE;
`endif
                end else if (addr_r == {NB_ADDR{1'b1}}) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = RECV;
                    accept_s     = i_rx_done;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (i_rx_done) begin
                    next_state_s = (i_rx_data == xor_r) ? DONE : ERROR;
                end else if (tmo_hit_s) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = CHECK;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Word assembly, timeout counter, memory write port and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r   <= 2'd0;
            tmo_r   <= '0;
            word_r  <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_r   <= '0;
`endif
        end else begin
            we_r    <= 1'b0;
            busy_r  <= is_busy(next_state_s);
            done_r  <= (next_state_s == DONE);
            error_r <= (next_state_s == ERROR);

            if (start_s) begin
                addr_r  <= '0;
                count_r <= '0;
                idx_r   <= 2'd0;
                tmo_r   <= '0;
`ifdef LOADER_CHECKSUM_EN
                xor_r   <= '0;
`endif
            end else if (accept_s) begin
                word_r <= assembled_s;
                idx_r  <= idx_r + 2'd1;
                tmo_r  <= '0;
`ifdef LOADER_CHECKSUM_EN
                xor_r  <= xor_r ^ i_rx_data;
`endif
                if ((state_r == RECV) && (idx_r == 2'd3)) begin
                    we_r   <= 1'b1;
                    data_r <= assembled_s;
                end else begin
                    we_r   <= 1'b0;
                end
            end else if ((state_r == RECV) && (idx_r != 2'd0)) begin
                tmo_r <= tmo_r + NB_TIMEOUT'(1);
`ifdef LOADER_CHECKSUM_EN
            end else if (state_r == CHECK) begin
                tmo_r <= tmo_r + NB_TIMEOUT'(1);
`endif
            end else if (state_r == WRITE) begin
                tmo_r <= '0;
            end else begin
                tmo_r <= tmo_r;
            end

            // The last address is never wrapped back to 0 on overflow
            if (state_r == WRITE) begin
                count_r <= count_r + {{NB_ADDR{1'b0}}, 1'b1};
                if (addr_r != {NB_ADDR{1'b1}}) begin
                    addr_r <= addr_r + {{(NB_ADDR-1){1'b0}}, 1'b1};
                end else begin
                    addr_r <= addr_r;
                end
            end
        end
    end

    assign o_mem_we     = we_r;
    assign o_mem_addr   = addr_r;
    assign o_mem_data   = data_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_error      = error_r;
    assign o_word_count = count_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected memory writes are queued as words are sent and checked on o_mem_we.
module tb_uart_prog_loader;
    localparam int NB_DATA = 8;
    localparam int NB_WORD = 32;
    localparam int NB_ADDR = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               i_rx_done = 1'b0;
    logic [NB_DATA-1:0] i_rx_data = 8'h00;
    logic               i_start = 1'b0;
    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_WORD-1:0] o_mem_data;
    logic               o_busy;
    logic               o_done;
    logic               o_error;
    logic [NB_ADDR:0]   o_word_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB_ADDR+NB_WORD-1:0] exp_q[$];
    logic [NB_ADDR-1:0] tb_addr;
    logic [7:0]         tb_xor;

    uart_prog_loader #(
        .NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR),
        .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(100), .NB_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_start(i_start), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_word_count(o_word_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && o_mem_we) begin
            check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [NB_ADDR+NB_WORD-1:0] e;
                e = exp_q.pop_front();
                check_eq("write_addr", 64'(o_mem_addr), 64'(e[NB_ADDR+NB_WORD-1:NB_WORD]));
                check_eq("write_data", 64'(o_mem_data), 64'(e[NB_WORD-1:0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_done = 1'b1;
        i_rx_data = b;
        tb_xor    = tb_xor ^ b;
        @(posedge clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic expect_write);
        if (expect_write) begin
            exp_q.push_back({tb_addr, w});
            tb_addr = tb_addr + 2'd1;
        end
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic start_load();
        tb_addr = '0;
        tb_xor  = 8'h00;
        pulse_start();
    endtask

    task automatic finish_halt();
        send_word(HALT, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
        idle(3);
    endtask

    task automatic check_end(input string tag, input logic done, input logic err, input int cnt);
        check_eq({tag, "_done"}, 64'(o_done), 64'(done));
        check_eq({tag, "_error"}, 64'(o_error), 64'(err));
        check_eq({tag, "_count"}, 64'(o_word_count), 64'(cnt));
        check_eq({tag, "_busy"}, 64'(o_busy), 64'd0);
        check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        tb_addr = '0;
        tb_xor  = 8'h00;
        idle(3);
        check_eq("rst_we", 64'(o_mem_we), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_done", 64'(o_done), 64'd0);
        check_eq("rst_error", 64'(o_error), 64'd0);
        check_eq("rst_count", 64'(o_word_count), 64'd0);
        reset = 1'b0;

        // byte in IDLE is ignored
        send_byte(8'h55);
        idle(2);
        check_eq("idle_busy", 64'(o_busy), 64'd0);

        // basic load
        start_load();
        check_eq("start_busy", 64'(o_busy), 64'd1);
        send_word(32'h2000_0013, 1'b1);
        idle(2);
        check_eq("mid_busy", 64'(o_busy), 64'd1);
        check_eq("mid_count", 64'(o_word_count), 64'd1);
        finish_halt();
        check_end("basic", 1'b1, 1'b0, 2);

        // timeout with partial word
        start_load();
        check_eq("restart_done", 64'(o_done), 64'd0);
        check_eq("restart_addr", 64'(o_mem_addr), 64'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(50);
        check_eq("tmo_early_error", 64'(o_error), 64'd0);
        idle(60);
        check_end("timeout", 1'b0, 1'b1, 0);

        // no timeout while idx is 0
        start_load();
        check_eq("restart_error", 64'(o_error), 64'd0);
        idle(500);
        check_eq("wait_busy", 64'(o_busy), 64'd1);
        check_eq("wait_error", 64'(o_error), 64'd0);

        // start mid-word is ignored
        send_byte(8'h11);
        pulse_start();
        exp_q.push_back({tb_addr, 32'h4433_2211});
        tb_addr = tb_addr + 2'd1;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        finish_halt();
        check_end("ignore_start", 1'b1, 1'b0, 2);

        // overflow
        start_load();
        for (int w = 1; w <= 4; w++) send_word(32'(w), 1'b1);
        idle(3);
        check_end("overflow", 1'b0, 1'b1, 4);
        send_word(32'h0000_0005, 1'b0);
        idle(3);
        check_eq("ovf_pending", 64'(exp_q.size()), 64'd0);

        // async reset mid-load
        start_load();
        send_byte(8'h01);
        send_byte(8'h02);
        #3 reset = 1'b1;
        #1;
        check_eq("arst_busy", 64'(o_busy), 64'd0);
        check_eq("arst_data", 64'(o_mem_data), 64'd0);
        check_eq("arst_addr", 64'(o_mem_addr), 64'd0);
        check_eq("arst_count", 64'(o_word_count), 64'd0);
        check_eq("arst_error", 64'(o_error), 64'd0);
        idle(2);
        reset = 1'b0;
        start_load();
        send_word(32'hDEAD_BEEF, 1'b1);
        finish_halt();
        check_end("after_reset", 1'b1, 1'b0, 2);

`ifdef LOADER_CHECKSUM_EN
        start_load();
        send_word(32'h0102_0304, 1'b1);
        send_word(HALT, 1'b1);
        send_byte(8'h04);
        idle(3);
        check_end("csum_ok", 1'b1, 1'b0, 2);
        start_load();
        send_word(32'h0102_0304, 1'b1);
        send_word(HALT, 1'b1);
        send_byte(8'h05);
        idle(3);
        check_end("csum_bad", 1'b0, 1'b1, 2);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Byte-to-word program loader directly downstream of uart_rx; consumes rx_done_tick/dout.
- Assembles received bytes little-endian into 32-bit instruction words and writes them to the MIPS instruction memory at incrementing addresses.
- Terminates on a HALT word; flags errors for inter-byte timeout or memory overflow.
- Status outputs feed the debug unit / LEDs.

Parameters:
- NB_DATA, 8: UART byte width.
- NB_WORD, 32: instruction word width; must equal 4*NB_DATA.
- NB_ADDR, 8: instruction memory address width (2^NB_ADDR words).
- HALT_WORD, 32'hFFFFFFFF: end-of-program word.
- TIMEOUT_CYC, 1000000: maximum clk cycles allowed between bytes of one word.
- NB_TIMEOUT, 20: timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_rx_done  in  1  one-cycle strobe: byte valid on i_rx_data.
- i_rx_data  in  NB_DATA  received byte.
- i_start  in  1  one-cycle pulse: arm a new load.
- o_mem_we  out  1  instruction memory write enable, one-cycle pulse.
- o_mem_addr  out  NB_ADDR  write address.
- o_mem_data  out  NB_WORD  write data.
- o_busy  out  1  high in RECV, WRITE and CHECK.
- o_done  out  1  load completed, sticky.
- o_error  out  1  load aborted, sticky.
- o_word_count  out  NB_ADDR+1  words written in the current load, HALT included.

Behaviour:
- Reset (async, any state): state=IDLE; byte index=0; timeout counter=0; word register=0; all outputs 0.
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE, ERROR.
- IDLE / DONE / ERROR, on i_start:
  - Go to RECV.
  - Clear o_mem_addr, o_word_count, byte index, o_done, o_error.
  - i_rx_done in these states is ignored.
- RECV:
  - Each i_rx_done places i_rx_data in word byte [idx]: idx 0 -> bits 7:0, ..., idx 3 -> bits 31:24. idx increments.
  - On the 4th byte, the next cycle is WRITE.
  - i_start is ignored.
- Timeout:
  - The counter runs only in RECV with idx != 0, and resets on every accepted byte.
  - When it reaches TIMEOUT_CYC: go to ERROR and discard the partial word (no write).
  - With idx == 0, RECV waits indefinitely.
- WRITE (exactly 1 cycle):
  - o_mem_we=1, with o_mem_data=assembled word and o_mem_addr=current address.
  - The following cycle: o_mem_we=0, address+1, o_word_count+1.
  - Next state:
    - word == HALT_WORD -> DONE (or CHECK with macro).
    - else address was 2^NB_ADDR-1 (overflow, no wrap) -> ERROR.
    - else -> RECV with idx=0.
  - An i_rx_done coincident with WRITE is accepted as byte 0 of the next word if the next state is RECV; otherwise it is dropped.
- o_mem_addr/o_mem_data are stable across the whole WRITE cycle; outside WRITE they hold their last value.
- DONE/ERROR: o_done/o_error held high until the next i_start or reset. They are never both high.
- Simultaneous i_start and i_rx_done in IDLE: start wins; the byte is dropped.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR is computed over all received bytes of the load, HALT bytes included.
  - After the HALT WRITE, the FSM enters CHECK and waits for one more byte (the timeout applies, measured from the HALT write).
  - Byte == running XOR -> DONE; mismatch or timeout -> ERROR. The HALT word is already written either way.
  - o_busy stays high in CHECK.
- Undefined: no CHECK state and no XOR logic; HALT goes directly to DONE.

Test Plan:
- Basic load: i_start; send bytes 0x13,0x00,0x00,0x20, then FF,FF,FF,FF -> two o_mem_we pulses: addr0=0x20000013, addr1=0xFFFFFFFF; o_done=1; o_word_count=2; o_error=0.
- Timeout: TIMEOUT_CYC=100; send 0xAA,0xBB then idle 100 cycles -> o_error=1, no o_mem_we. Separately, idle 500 cycles with idx=0 -> still RECV, o_busy=1.
- Overflow: NB_ADDR=2; send 4 non-HALT words 0x00000001..0x00000004 -> writes to addr 0..3, then o_error=1, o_word_count=4, no write to addr 0 again.
- Restart and ignore: i_start mid-word is ignored (word still completes correctly); i_start after DONE clears o_done and begins again at addr 0.
- Reset mid-load: assert reset after 2 bytes -> all outputs 0 immediately (async). A new i_start load then writes from addr 0 with clean byte alignment.
- Checksum (macro): send word 0x01020304 + HALT + 0x04 -> o_done. Same sequence + 0x05 -> o_error; both words still written.
